// File: rtl/dot_chunk_feeder_pkg.sv
// Shared definitions for the dot-product feeder and its result collector:
// default geometry, FSM state encoding and chunk-count helpers.
package dot_chunk_feeder_pkg;

  localparam int DEF_ELEMENT_WIDTH    = 32;
  localparam int DEF_NO_OF_UNITS      = 8;
  localparam int DEF_CHUNK_ADDR_WIDTH = 5;
  localparam int DEF_FLUSH_BEATS      = 2;
  localparam int DEF_MAX_ELEMENTS     = DEF_NO_OF_UNITS << DEF_CHUNK_ADDR_WIDTH;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_FLUSH    = 3'd2;
  localparam logic [2:0] ST_WAIT_FIN = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  // Number of chunks needed to cover num elements, den elements per chunk.
  function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
    return (num + den - 32'd1) / den;
  endfunction

  // Element count limited to what the chunk RAMs can hold.
  function automatic logic [31:0] clamp_total(input logic [31:0] num, input logic [31:0] max_el);
    return (num > max_el) ? max_el : num;
  endfunction

endpackage

// File: rtl/dot_chunk_feeder_chunk_lane_mask.sv
// Zeroes every lane of a chunk whose global element index lies at or past
// the job's element count. Purely combinational.
module chunk_lane_mask
  import dot_chunk_feeder_pkg::*;
#(
  parameter int ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
  parameter int NO_OF_UNITS   = DEF_NO_OF_UNITS,
  parameter int IDX_W         = DEF_CHUNK_ADDR_WIDTH + 1
) (
  input  logic [IDX_W-1:0]                     i_chunk_idx,
  input  logic [31:0]                          i_total,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] i_data,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] o_data
);

  logic [31:0] w_base;

  assign w_base = 32'(i_chunk_idx) * 32'(NO_OF_UNITS);

  generate
    for (genvar gi = 0; gi < NO_OF_UNITS; gi++) begin : g_lane
      assign o_data[gi*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
        ((w_base + 32'(gi)) < i_total) ? i_data[gi*ELEMENT_WIDTH +: ELEMENT_WIDTH]
                                        : '0;
    end
  endgenerate

endmodule

// File: rtl/dot_chunk_feeder.sv
// Streams one matrix row and the operand vector, chunk by chunk, from the
// chunk RAMs to the dot-product stage, then two zero flush beats, then waits
// for the consumer's finish and pulses done.
// The beat presented is either the RAM data arriving this cycle (masked) or,
// after a stall, the single holding register. A read is issued only when the
// beat position will be free next cycle, so returned data is never dropped.
module dot_chunk_feeder
  import dot_chunk_feeder_pkg::*;
#(
  parameter int ELEMENT_WIDTH    = DEF_ELEMENT_WIDTH,
  parameter int NO_OF_UNITS      = DEF_NO_OF_UNITS,
  parameter int CHUNK_ADDR_WIDTH = DEF_CHUNK_ADDR_WIDTH,
  parameter int FLUSH_BEATS      = DEF_FLUSH_BEATS
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [31:0]                          total,
  input  logic                                 I_am_ready,
  input  logic                                 finish,
  output logic                                 mem_rd_en,
  output logic [CHUNK_ADDR_WIDTH-1:0]          mem_rd_addr,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] row_rd_data,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] vec_rd_data,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] first_row_plus_additional,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] vector2,
  output logic                                 outsider_read_now,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 total_clamped
);

  localparam int BW       = ELEMENT_WIDTH * NO_OF_UNITS;
  localparam int CNT_W    = CHUNK_ADDR_WIDTH + 1;
  localparam int FW       = $clog2(FLUSH_BEATS + 1);
  localparam int MAX_ELEM = NO_OF_UNITS << CHUNK_ADDR_WIDTH;

  logic [2:0]                  r_state;
  logic [31:0]                 r_total;
  logic [CNT_W-1:0]            r_n_chunks;
  logic [CNT_W-1:0]            r_beat_cnt;
  logic [FW-1:0]               r_flush_cnt;
  logic                        r_fin_seen;
  logic                        r_clamped;
  logic [CHUNK_ADDR_WIDTH-1:0] r_rd_addr;
  logic                        r_rd_done;
  logic                        r_inflight;
  logic                        r_hold_valid;
  logic [BW-1:0]               r_hold_row;
  logic [BW-1:0]               r_hold_vec;

  logic [31:0]      w_total_cl;
  logic [CNT_W-1:0] w_n_chunks;
  logic             w_start_acc;
  logic             w_data_beat;
  logic             w_beat_valid;
  logic             w_xfer;
  logic             w_issue;
  logic             w_last_data;
  logic             w_last_flush;
  logic             w_last_addr;
  logic [BW-1:0]    w_row_masked;
  logic [BW-1:0]    w_vec_masked;

  assign w_total_cl  = clamp_total(total, 32'(MAX_ELEM));
  assign w_n_chunks  = CNT_W'(ceil_div(w_total_cl, 32'(NO_OF_UNITS)));
  assign w_start_acc = (r_state == ST_IDLE) && start;

  assign w_data_beat  = (r_state == ST_FETCH) && (r_hold_valid || r_inflight);
  assign w_beat_valid = w_data_beat || (r_state == ST_FLUSH);
  assign w_xfer       = w_beat_valid && I_am_ready;

  // Slot rule: the beat position is empty now, or it empties at this edge.
  assign w_issue = (r_state == ST_FETCH) && !r_rd_done && (r_n_chunks != '0) &&
                   (!w_data_beat || w_xfer);

  assign w_last_data  = (r_beat_cnt == (r_n_chunks - CNT_W'(1)));
  assign w_last_flush = (r_flush_cnt == FW'(FLUSH_BEATS - 1));
  assign w_last_addr  = (CNT_W'(r_rd_addr) == (r_n_chunks - CNT_W'(1)));

  // Chunk being presented is always the next one to transfer (in-order reads).
  chunk_lane_mask #(
    .ELEMENT_WIDTH(ELEMENT_WIDTH), .NO_OF_UNITS(NO_OF_UNITS), .IDX_W(CNT_W)
  ) u_row_mask (
    .i_chunk_idx(r_beat_cnt), .i_total(r_total), .i_data(row_rd_data), .o_data(w_row_masked)
  );

  chunk_lane_mask #(
    .ELEMENT_WIDTH(ELEMENT_WIDTH), .NO_OF_UNITS(NO_OF_UNITS), .IDX_W(CNT_W)
  ) u_vec_mask (
    .i_chunk_idx(r_beat_cnt), .i_total(r_total), .i_data(vec_rd_data), .o_data(w_vec_masked)
  );

  assign mem_rd_en                 = w_issue;
  assign mem_rd_addr               = r_rd_addr;
  assign outsider_read_now         = w_beat_valid;
  assign first_row_plus_additional = r_hold_valid ? r_hold_row : (r_inflight ? w_row_masked : '0);
  assign vector2                   = r_hold_valid ? r_hold_vec : (r_inflight ? w_vec_masked : '0);
  assign busy                      = (r_state != ST_IDLE);
  assign done                      = (r_state == ST_DONE);
  assign total_clamped             = r_clamped;

  // Job sequencing: accept start, count data and flush beats, await finish.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_total     <= '0;
      r_n_chunks  <= '0;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
      r_fin_seen  <= 1'b0;
      r_clamped   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_FETCH;
            r_total     <= w_total_cl;
            r_n_chunks  <= w_n_chunks;
            r_clamped   <= (total > 32'(MAX_ELEM));
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
            r_fin_seen  <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (r_n_chunks == '0) begin
            r_state <= ST_DONE;
          end else if (w_xfer) begin
            if (w_last_data) r_state <= ST_FLUSH;
            else             r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          end
        end
        ST_FLUSH: begin
          if (finish) r_fin_seen <= 1'b1;
          if (w_xfer) begin
            if (w_last_flush) r_state <= ST_WAIT_FIN;
            else              r_flush_cnt <= r_flush_cnt + FW'(1);
          end
        end
        ST_WAIT_FIN: begin
          if (finish || r_fin_seen) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Read address generation; the address parks on the last chunk, never wraps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_addr  <= '0;
      r_rd_done  <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_start_acc) begin
        r_rd_addr <= '0;
        r_rd_done <= 1'b0;
      end else if (w_issue) begin
        if (w_last_addr) r_rd_done <= 1'b1;
        else             r_rd_addr <= r_rd_addr + CHUNK_ADDR_WIDTH'(1);
      end
    end
  end

  // Holding register: captures an arriving chunk the consumer did not take.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hold_valid <= 1'b0;
      r_hold_row   <= '0;
      r_hold_vec   <= '0;
    end else if (w_xfer) begin
      r_hold_valid <= 1'b0;
    end else if (r_inflight && !r_hold_valid) begin
      r_hold_valid <= 1'b1;
      r_hold_row   <= w_row_masked;
      r_hold_vec   <= w_vec_masked;
    end
  end

endmodule
